// File: rtl/oddr_tx_serializer.sv
// ============================================================================
// Module      : oddr_tx_serializer
// Description : Serializes parallel words into two bits per clock (D1/D2) for
//               a DDR output cell. One holding register plus a shift register
//               let back-to-back words stream without idle gaps. Define
//               ODDR_SER_PARITY_EN to append a trailing even-parity beat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module oddr_tx_serializer #(
    parameter int   DATA_W    = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_D1   = 1'b0,
    parameter logic IDLE_D2   = 1'b0
) (
    input  logic              C,
    input  logic              R,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              D1,
    output logic              D2,
    output logic              CE,
    output logic              active,
    output logic              first_beat
);

    localparam int BEATS = DATA_W / 2;
`ifdef ODDR_SER_PARITY_EN
    localparam int LAST_BEAT = BEATS;
`else
    localparam int LAST_BEAT = BEATS - 1;
`endif
    localparam int CNT_W = (LAST_BEAT > 0) ? $clog2(LAST_BEAT + 1) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(LAST_BEAT);
`ifdef ODDR_SER_PARITY_EN
    localparam logic [CNT_W-1:0] c_last_data = CNT_W'(BEATS - 1);
`endif

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_hold;
    logic                r_hold_valid;
    logic [DATA_W-1:0]   r_shift;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_d1;
    logic                r_d2;
    logic                r_ce;
    logic                r_first;
`ifdef ODDR_SER_PARITY_EN
    logic                r_par;
`endif

    logic                w_hold_drain;
    logic                w_in_ready;

    // The shifter always presents the next beat in its top (MSB-first) or
    // bottom (LSB-first) two bits; consumed bits are shifted out.
    function automatic logic beat_d1(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic beat_d2(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-2] : w[1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_next(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? (w << 2) : (w >> 2);
    endfunction

    assign w_hold_drain = r_hold_valid && ((r_state == ST_IDLE) || (r_cnt == c_last));
    assign w_in_ready   = !r_hold_valid || w_hold_drain;

    assign in_ready   = w_in_ready;
    assign D1         = r_d1;
    assign D2         = r_d2;
    assign CE         = r_ce;
    assign active     = r_ce;
    assign first_beat = r_first;

    always_ff @(posedge C) begin
        if (R) begin
            r_state      <= ST_IDLE;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_shift      <= '0;
            r_cnt        <= '0;
            r_d1         <= IDLE_D1;
            r_d2         <= IDLE_D2;
            r_ce         <= 1'b0;
            r_first      <= 1'b0;
`ifdef ODDR_SER_PARITY_EN
            r_par        <= 1'b0;
`endif
        end else begin
            // Holding register: a new word may replace one that drains this edge.
            if (in_valid && w_in_ready) begin
                r_hold       <= in_data;
                r_hold_valid <= 1'b1;
            end else if (w_hold_drain) begin
                r_hold_valid <= 1'b0;
            end

            if (w_hold_drain) begin
                r_state <= ST_SHIFT;
                r_shift <= shift_next(r_hold);
                r_cnt   <= '0;
                r_d1    <= beat_d1(r_hold);
                r_d2    <= beat_d2(r_hold);
                r_ce    <= 1'b1;
                r_first <= 1'b1;
`ifdef ODDR_SER_PARITY_EN
                r_par   <= ^r_hold;
`endif
            end else if (r_state == ST_SHIFT) begin
                if (r_cnt == c_last) begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_d1    <= IDLE_D1;
                    r_d2    <= IDLE_D2;
                    r_ce    <= 1'b0;
                    r_first <= 1'b0;
                end else begin
                    r_cnt   <= r_cnt + CNT_W'(1);
                    r_first <= 1'b0;
`ifdef ODDR_SER_PARITY_EN
                    if (r_cnt == c_last_data) begin
                        r_d1 <= r_par;
                        r_d2 <= ~r_par;
                    end else begin
                        r_d1    <= beat_d1(r_shift);
                        r_d2    <= beat_d2(r_shift);
                        r_shift <= shift_next(r_shift);
                    end
`else
                    r_d1    <= beat_d1(r_shift);
                    r_d2    <= beat_d2(r_shift);
                    r_shift <= shift_next(r_shift);
`endif
                end
            end
        end
    end

endmodule

`default_nettype wire
